rr_arbiter_hold: RTL and testbench
==================================

# rr_arbiter_hold

Parameterised round-robin arbiter that shares a single resource among N requesters with registered one-hot grants. An owner keeps the grant while it holds its request, and is pre-empted after MAX_HOLD cycles only if another requester is waiting. The block is the multi-requester, fairness-bounded successor to the team's 2-way `r`/`g` arbiter. It sits between requesting agents and the shared datapath resource.

## Interface

**Parameters**
- `N`, default 4: number of requesters (≥2).
- `MAX_HOLD`, default 8: maximum consecutive grant cycles under contention (≥1).
- `IW`, default $clog2(N): derived width of `gnt_id`. Do not override.

**Ports**
- `clk`  in  1: single clock; everything is sampled on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset. Sampled on the `clk` rising edge only.
- `req`  in  N: request vector; bit i is agent i. Level-sensitive.
- `gnt`  out  N: one-hot grant, registered. All zeros when no owner.
- `gnt_valid`  out  1: high when `gnt` is non-zero.
- `gnt_id`  out  IW: index of the current owner. Value is 0 when `gnt_valid` = 0.

## Operation

**State**
- FSM with states IDLE and OWN.
- `owner[IW-1:0]`: current owner index.
- `ptr[IW-1:0]`: round-robin priority pointer.
- `hold_cnt`: counts 0..MAX_HOLD and saturates at MAX_HOLD.

**Reset** (`rst_n` = 0 at an edge)
- State = IDLE; `gnt` = 0; `gnt_valid` = 0; `gnt_id` = 0; `ptr` = 0; `hold_cnt` = 0.
- Reset overrides everything, including an active ownership.

**Selection function `pick(mask)`**
- Returns the first set bit of `mask`, searching `ptr`, `ptr`+1, … , `ptr`+N-1, all mod N.

**Grant event** (a new owner k is granted at an edge)
- `gnt` = 1<<k; `owner` = k; `hold_cnt` = 1; `ptr` = (k+1) mod N, wrapping N-1 → 0.

**IDLE**
- If `req` ≠ 0: grant `pick(req)` and go to OWN.
- Otherwise stay in IDLE with `gnt` = 0.

**OWN**, evaluated each edge with `others` = `req` with the `owner` bit cleared:
- **Release**: `req[owner]` = 0.
  - If `others` ≠ 0: grant `pick(others)` directly in the same edge. No idle cycle.
  - Else: go to IDLE with `gnt` = 0.
- **Pre-empt**: `req[owner]` = 1, `hold_cnt` = MAX_HOLD, and `others` ≠ 0. Grant `pick(others)`.
- **Hold**: otherwise keep `owner`; `hold_cnt` = min(`hold_cnt`+1, MAX_HOLD).
- With no contention the owner holds indefinitely.

**Invariants**
- `gnt` is always zero or one-hot.
- `gnt_valid` = |`gnt`.
- `gnt_id` matches `gnt`.
- A requester never receives a grant without `req` having been high at the granting edge.

## Timing

**Latency and handshake**
- `req` → `gnt` latency is 1 cycle: `req` sampled at edge t gives `gnt` valid after edge t.
- Release latency is 1 cycle: `req[owner]` low at edge t means `gnt` bit low after edge t.
- Requesters must hold `req` until granted; dropping `req` before grant withdraws the request.

**Outputs**
- All outputs are registered; there are no combinational paths from `req` to the outputs.

**Fairness bound**
- Under full contention each owner holds exactly MAX_HOLD cycles.
- Any waiting requester is granted within (N-1)·MAX_HOLD+1 cycles.

**Boundary cases**
- Simultaneous release by the owner and a new request from the same agent at the same edge: treated as Hold (`req[owner]` is sampled high).
- MAX_HOLD = 1: the grant rotates every cycle under contention.
- Reset mid-operation: outputs reach their reset values after the first edge with `rst_n` = 0. The first grant after release follows `ptr` = 0.

## Test plan

Bench settings: N = 4, MAX_HOLD = 4, clock period 8 ns.

1. **Reset**: `rst_n` = 0 for 2 edges with `req` = 4'b1111.
   - During reset: `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0.
   - First edge after `rst_n` = 1: `gnt` = 4'b0001.
2. **Lone requester**: `req` = 4'b0001 for 12 cycles, then 0.
   - `gnt` = 0001 one edge after `req` rises and is held all 12 cycles (no pre-emption without contention).
   - `gnt` = 0000 one edge after `req` drops.
3. **Full contention**: `req` = 4'b1111 held.
   - `gnt` sequence is 0001, 0010, 0100, 1000, 0001, each for exactly 4 cycles.
   - `gnt_id` sequence is 0, 1, 2, 3, 0.
4. **Handoff on release**: owner 0 granted, `req` = 4'b0101; drop `req[0]` after 2 cycles.
   - `gnt` goes 0001 → 0100 at a single edge, with no zero cycle.
5. **Pointer wrap**: grant agent 2, release, idle 3 cycles (`ptr` = 3), then `req` = 4'b0101.
   - `gnt` = 0001: search order 3, 0 finds agent 0.
6. **Reset mid-ownership**: `gnt` = 0010 with `req` = 4'b1110; pulse `rst_n` low for 1 edge.
   - `gnt` = 0 after that edge.
   - Next edge after release: `gnt` = 0010 (`ptr` = 0, first set bit is agent 1).

Source files
------------

// File: rtl/rr_arbiter_hold.sv
// rr_arbiter_hold: round-robin arbiter with bounded hold for N requesters.
// An owner keeps its grant while it holds req; under contention it is
// pre-empted after MAX_HOLD consecutive grant cycles.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - synchronous active-low reset
//   req       - request vector, bit i = agent i (level-sensitive)
//   gnt       - registered one-hot grant (zero when no owner)
//   gnt_valid - registered, high when gnt is non-zero
//   gnt_id    - registered owner index, 0 when gnt_valid is low
module rr_arbiter_hold #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id
);

  localparam int unsigned NU = N;
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            valid_q, valid_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;

  // Decisions from the next-state process, consumed by the output process
  logic            do_grant_c;
  logic            do_release_c;
  logic            do_hold_c;
  logic [N-1:0]    grant_mask_c;
  logic [N-1:0]    others_c;
  logic [IW-1:0]   pick_c;

  // First set bit of mask searching from p upwards, wrapping N-1 -> 0
  function automatic logic [IW-1:0] pick(input logic [N-1:0] mask,
                                         input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    logic          found;
    idx   = '0;
    found = 1'b0;
    cand  = p;
    for (int unsigned i = 0; i < NU; i++) begin
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = (cand == IW'(NU - 1)) ? '0 : cand + 1'b1;
    end
    return idx;
  endfunction

  // State register and all registered datapath/outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state: classify the edge as grant, release-to-idle or hold
  always_comb begin
    state_d      = state_q;
    do_grant_c   = 1'b0;
    do_release_c = 1'b0;
    do_hold_c    = 1'b0;
    grant_mask_c = '0;
    others_c     = req & ~(N'(1) << owner_q);
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          do_grant_c   = 1'b1;
          grant_mask_c = req;
          state_d      = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!req[owner_q]) begin
          // Release hands straight over to a waiting agent when there is one
          if (|others_c) begin
            do_grant_c   = 1'b1;
            grant_mask_c = others_c;
          end else begin
            do_release_c = 1'b1;
            state_d      = ST_IDLE;
          end
        end else if ((hold_q == HW'(MAX_HOLD)) && (|others_c)) begin
          do_grant_c   = 1'b1;
          grant_mask_c = others_c;
        end else begin
          do_hold_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values
  always_comb begin
    gnt_d   = gnt_q;
    valid_d = valid_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    pick_c  = pick(grant_mask_c, ptr_q);
    if (do_grant_c) begin
      gnt_d   = N'(1) << pick_c;
      valid_d = 1'b1;
      owner_d = pick_c;
      hold_d  = HW'(1);
      ptr_d   = (pick_c == IW'(NU - 1)) ? '0 : pick_c + 1'b1;
    end else if (do_release_c) begin
      gnt_d   = '0;
      valid_d = 1'b0;
      owner_d = '0;
      hold_d  = '0;
    end else if (do_hold_c) begin
      if (hold_q != HW'(MAX_HOLD)) begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = owner_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Directed bench for rr_arbiter_hold with N=4, MAX_HOLD=4, 8 ns clock.
module tb_rr_arbiter_hold;

  localparam int N  = 4;
  localparam int MH = 4;
  localparam int IW = 2;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_id;

  int n_cmp;
  int n_bad;

  rr_arbiter_hold #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Advance one edge; outputs are sampled 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    for (int e = 0; e < 2; e++) begin
      step();
      n_cmp++;
      if ({gnt, gnt_valid, gnt_id} !== 7'b0000_0_00) begin
        n_bad++;
        $display("FAIL reset_hold edge%0d: gnt=%b valid=%b id=%0d want gnt=0000 valid=0 id=0",
                 e, gnt, gnt_valid, gnt_id);
      end
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({gnt, gnt_valid, gnt_id} !== 7'b0001_1_00) begin
      n_bad++;
      $display("FAIL reset_first_grant: gnt=%b valid=%b id=%0d want gnt=0001 valid=1 id=0",
               gnt, gnt_valid, gnt_id);
    end
  endtask

  task automatic test_lone();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      step();
      n_cmp++;
      if ({gnt, gnt_valid, gnt_id} !== 7'b0001_1_00) begin
        n_bad++;
        $display("FAIL lone_hold cyc%0d: gnt=%b valid=%b id=%0d want gnt=0001 valid=1 id=0",
                 c, gnt, gnt_valid, gnt_id);
      end
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if ({gnt, gnt_valid, gnt_id} !== 7'b0000_0_00) begin
      n_bad++;
      $display("FAIL lone_release: gnt=%b valid=%b id=%0d want gnt=0000 valid=0 id=0",
               gnt, gnt_valid, gnt_id);
    end
  endtask

  task automatic test_contention();
    logic [N-1:0]  exp_g;
    logic [IW-1:0] exp_id;
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_id = IW'(g % N);
      exp_g  = N'(1) << exp_id;
      for (int c = 0; c < MH; c++) begin
        step();
        n_cmp++;
        if ({gnt, gnt_valid, gnt_id} !== {exp_g, 1'b1, exp_id}) begin
          n_bad++;
          $display("FAIL contention slot%0d cyc%0d: gnt=%b id=%0d want gnt=%b id=%0d",
                   g, c, gnt, gnt_id, exp_g, exp_id);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_handoff();
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({gnt, gnt_valid, gnt_id} !== 7'b0001_1_00) begin
        n_bad++;
        $display("FAIL handoff_owner0 cyc%0d: gnt=%b id=%0d want gnt=0001 id=0",
                 c, gnt, gnt_id);
      end
      if (c < 2) step();
    end
    req = 4'b0100;
    step();
    n_cmp++;
    if ({gnt, gnt_valid, gnt_id} !== 7'b0100_1_10) begin
      n_bad++;
      $display("FAIL handoff_direct: gnt=%b valid=%b id=%0d want gnt=0100 valid=1 id=2",
               gnt, gnt_valid, gnt_id);
    end
    req = '0;
    step();
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    req = 4'b0100;
    step();
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL wrap_grant2: gnt=%b want 0100", gnt);
    end
    req = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if ({gnt, gnt_valid, gnt_id} !== 7'b0000_0_00) begin
        n_bad++;
        $display("FAIL wrap_idle cyc%0d: gnt=%b valid=%b id=%0d want all zero",
                 c, gnt, gnt_valid, gnt_id);
      end
    end
    req = 4'b0101;
    step();
    n_cmp++;
    if ({gnt, gnt_valid, gnt_id} !== 7'b0001_1_00) begin
      n_bad++;
      $display("FAIL wrap_pick0: gnt=%b id=%0d want gnt=0001 id=0", gnt, gnt_id);
    end
    req = '0;
    step();
  endtask

  // Release handoff must search from ptr=3, so agent 3 beats agent 1
  task automatic test_ptr_order();
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b1010;
    step();
    n_cmp++;
    if ({gnt, gnt_valid, gnt_id} !== 7'b1000_1_11) begin
      n_bad++;
      $display("FAIL ptr_order: gnt=%b id=%0d want gnt=1000 id=3", gnt, gnt_id);
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010;
    step();
    req = 4'b1110;
    step();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL midrst_before: gnt=%b want 0010", gnt);
    end
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({gnt, gnt_valid, gnt_id} !== 7'b0000_0_00) begin
      n_bad++;
      $display("FAIL midrst_cleared: gnt=%b valid=%b id=%0d want all zero",
               gnt, gnt_valid, gnt_id);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({gnt, gnt_valid, gnt_id} !== 7'b0010_1_01) begin
      n_bad++;
      $display("FAIL midrst_regrant: gnt=%b id=%0d want gnt=0010 id=1", gnt, gnt_id);
    end
    req = '0;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = '0;
    test_reset();
    test_lone();
    test_contention();
    test_handoff();
    test_ptr_wrap();
    test_ptr_order();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
